// File: rtl/irq_pkg.sv
// Shared types and widths for the interrupt controller.
// Imported by the interface, the encoder and the top.
package irq_pkg;

    localparam int IRQ_ID_W = 3;
    localparam int ADDR_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_if.sv
// Request/handshake bundle between pipeline and interrupt controller.
// master = pipeline side, slave = controller side.
interface irq_if #(
    parameter int NUM_SRC = 4
);
    import irq_pkg::*;

    logic [NUM_SRC-1:0]  irq_src;
    logic                mask_we;
    logic [NUM_SRC-1:0]  mask_wdata;
    logic                stall;
    logic                irq_ack;
    logic                irq_done;
    logic                interrupt;
    logic [ADDR_W-1:0]   irq_vec;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [NUM_SRC-1:0]  pending;
    logic                in_service;

    modport master (
        output irq_src, mask_we, mask_wdata, stall, irq_ack, irq_done,
        input  interrupt, irq_vec, irq_id, pending, in_service
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, stall, irq_ack, irq_done,
        output interrupt, irq_vec, irq_id, pending, in_service
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          i_req,
    output logic                  o_valid,
    output logic [IRQ_ID_W-1:0]   o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // scan downward so the lowest index is written last
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: edge detect, pending/mask,
// fixed-priority grant and a non-nesting REQ/SERVICE handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [7:0]  VEC_BASE  = 8'hF0,
    parameter int          VEC_SHIFT = 1
) (
    input  logic clk,
    input  logic reset,
    irq_if.slave bus
);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_SRC-1:0]  r_src_q;
    logic [NUM_SRC-1:0]  r_pend;
    logic [NUM_SRC-1:0]  r_mask;
    logic [IRQ_ID_W-1:0] r_id;
    logic [ADDR_W-1:0]   r_vec;

    logic [NUM_SRC-1:0]  w_rise;
    logic [NUM_SRC-1:0]  w_clr;
    logic                w_valid;
    logic [IRQ_ID_W-1:0] w_win;
    logic                w_grant;
    logic                w_ack;
    logic [ADDR_W-1:0]   w_vec;

    irq_prio_enc #(.N(NUM_SRC)) u_enc (
        .i_req   (r_pend & r_mask),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    assign w_rise  = bus.irq_src & ~r_src_q;
    assign w_grant = (r_state == IDLE) && w_valid && !bus.stall;
    assign w_ack   = (r_state == REQ) && bus.irq_ack;
    assign w_clr   = w_ack ? (NUM_SRC'(1) << r_id) : '0;
    assign w_vec   = VEC_BASE + (ADDR_W'(w_win) << VEC_SHIFT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant)      w_next = REQ;
            REQ:     if (bus.irq_ack)  w_next = SERVICE;
            SERVICE: if (bus.irq_done) w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // sampled even in reset so a held-high line is not seen as an edge
        r_src_q <= bus.irq_src;
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_mask  <= '0;
            r_id    <= '0;
            r_vec   <= VEC_BASE;
        end else begin
            r_state <= w_next;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
            if (w_grant) begin
                r_id  <= w_win;
                r_vec <= w_vec;
            end
        end
    end

    assign bus.interrupt  = (r_state == REQ);
    assign bus.in_service = (r_state == SERVICE);
    assign bus.irq_id     = r_id;
    assign bus.irq_vec    = r_vec;
    assign bus.pending    = r_pend;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table plus a
// randomized run against a rule-level reference model.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    irq_if #(.NUM_SRC(N)) bus ();

    irq_controller #(
        .NUM_SRC   (N),
        .VEC_BASE  (8'hF0),
        .VEC_SHIFT (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] src;
        logic       mwe;
        logic [3:0] mwd;
        logic       stall;
        logic       ack;
        logic       done;
        logic       eint;
        logic [2:0] eid;
        logic [7:0] evec;
        logic [3:0] epend;
        logic       eins;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state, expressed as the rules read
    bit m_prev[N];
    bit m_pend[N];
    bit m_mask[N];
    int m_phase;
    int m_id;
    int m_vec;

    function automatic void v(
        input logic rst, input logic [3:0] src, input logic mwe,
        input logic [3:0] mwd, input logic stall, input logic ack,
        input logic done, input logic eint, input logic [2:0] eid,
        input logic [7:0] evec, input logic [3:0] epend, input logic eins
    );
        vec_t r;
        r.rst = rst; r.src = src; r.mwe = mwe; r.mwd = mwd;
        r.stall = stall; r.ack = ack; r.done = done;
        r.eint = eint; r.eid = eid; r.evec = evec;
        r.epend = epend; r.eins = eins;
        tbl.push_back(r);
    endfunction

    task automatic drive(
        input logic rst, input logic [3:0] src, input logic mwe,
        input logic [3:0] mwd, input logic stall, input logic ack,
        input logic done
    );
        reset          = rst;
        bus.irq_src    = src;
        bus.mask_we    = mwe;
        bus.mask_wdata = mwd;
        bus.stall      = stall;
        bus.irq_ack    = ack;
        bus.irq_done   = done;
    endtask

    task automatic check(input string name, input logic [16:0] want);
        logic [16:0] got;
        got = {bus.interrupt, bus.irq_id, bus.irq_vec,
               bus.pending, bus.in_service};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: {int,id,vec,pend,insvc} got %h want %h",
                     name, got, want);
        end
    endtask

    function automatic void model_step(
        input logic rst, input logic [3:0] src, input logic mwe,
        input logic [3:0] mwd, input logic stall, input logic ack,
        input logic done
    );
        int win;
        win = -1;
        if (rst) begin
            m_phase = 0;
            m_id    = 0;
            m_vec   = 240;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_mask[i] = 1'b0;
                m_prev[i] = src[i];
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (win < 0 && m_pend[i] && m_mask[i]) win = i;
        end
        case (m_phase)
            0: if (win >= 0 && !stall) begin
                m_phase = 1;
                m_id    = win;
                m_vec   = (240 + win * 2) % 256;
            end
            1: if (ack) begin
                m_pend[m_id] = 1'b0;
                m_phase      = 2;
            end
            default: if (done) m_phase = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (src[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = src[i];
            if (mwe) m_mask[i] = mwd[i];
        end
    endfunction

    function automatic logic [16:0] model_out();
        logic [3:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        return {m_phase == 1, 3'(m_id), 8'(m_vec), p, m_phase == 2};
    endfunction

    initial begin
        logic [3:0] src;
        logic       rst, mwe, stall, ack, done;
        logic [3:0] mwd;

        // rst src mwe mwd stall ack done | int id vec pend insvc
        v(1, 4'h0, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h0, 1, 4'hF, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h4, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 2, 8'hF4, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 2, 8'hF4, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 2, 8'hF4, 4'h0, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 2, 8'hF4, 4'h0, 0);
        v(0, 4'hA, 0, 4'h0, 0, 0, 0,  0, 2, 8'hF4, 4'hA, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 1, 8'hF2, 4'hA, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 1, 8'hF2, 4'h8, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 1, 8'hF2, 4'h8, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 3, 8'hF6, 4'h8, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 3, 8'hF6, 4'h0, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 3, 8'hF6, 4'h0, 0);
        v(0, 4'h0, 1, 4'h0, 0, 0, 0,  0, 3, 8'hF6, 4'h0, 0);
        v(0, 4'h1, 0, 4'h0, 0, 0, 0,  0, 3, 8'hF6, 4'h1, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  0, 3, 8'hF6, 4'h1, 0);
        v(0, 4'h0, 1, 4'h1, 0, 0, 0,  0, 3, 8'hF6, 4'h1, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 0, 8'hF0, 4'h1, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 0, 8'hF0, 4'h0, 1);
        v(0, 4'h0, 1, 4'hF, 0, 0, 1,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h2, 0, 4'h0, 1, 0, 0,  0, 0, 8'hF0, 4'h2, 0);
        v(0, 4'h0, 0, 4'h0, 1, 0, 0,  0, 0, 8'hF0, 4'h2, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 1, 8'hF2, 4'h2, 0);
        v(0, 4'h0, 0, 4'h0, 1, 0, 0,  1, 1, 8'hF2, 4'h2, 0);
        v(0, 4'h0, 0, 4'h0, 1, 1, 1,  0, 1, 8'hF2, 4'h0, 1);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 1, 8'hF2, 4'h0, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 1, 8'hF2, 4'h0, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 1, 8'hF2, 4'h0, 0);
        v(0, 4'h4, 0, 4'h0, 0, 0, 0,  0, 1, 8'hF2, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 2, 8'hF4, 4'h4, 0);
        v(0, 4'h4, 0, 4'h0, 0, 1, 0,  0, 2, 8'hF4, 4'h4, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 2, 8'hF4, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 2, 8'hF4, 4'h4, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 2, 8'hF4, 4'h0, 1);
        v(1, 4'h2, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h2, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h0, 1, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h0, 0);
        v(0, 4'h8, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h8, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h8, 0);
        v(0, 4'h8, 0, 4'h0, 0, 0, 0,  0, 0, 8'hF0, 4'h8, 0);
        v(0, 4'h0, 1, 4'h8, 0, 0, 0,  0, 0, 8'hF0, 4'h8, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  1, 3, 8'hF6, 4'h8, 0);
        v(0, 4'h0, 0, 4'h0, 0, 1, 0,  0, 3, 8'hF6, 4'h0, 1);
        v(0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 3, 8'hF6, 4'h0, 0);
        v(0, 4'h0, 0, 4'h0, 0, 0, 0,  0, 3, 8'hF6, 4'h0, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].src, tbl[k].mwe, tbl[k].mwd,
                  tbl[k].stall, tbl[k].ack, tbl[k].done);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k),
                  {tbl[k].eint, tbl[k].eid, tbl[k].evec,
                   tbl[k].epend, tbl[k].eins});
        end

        src = 4'h0;
        for (int c = 0; c < 800; c++) begin
            rst   = (c == 0) || ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) src[i] = ~src[i];
            end
            mwe   = ($urandom_range(0, 7) == 0);
            mwd   = 4'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            done  = ($urandom_range(0, 3) == 0);
            drive(rst, src, mwe, mwd, stall, ack, done);
            model_step(rst, src, mwe, mwd, stall, ack, done);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d", c), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
